// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - shifted partial-product accumulator with a single-entry result register
module product_accumulator #(
    parameter int PROD_W  = 77,
    parameter int ACC_W   = 265,
    parameter int SHIFT_W = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               in_first,
    input  logic               in_last,
    input  logic [SHIFT_W-1:0] in_shift,
    input  logic [PROD_W-1:0]  in_prod,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_result,
    output logic [4:0]         out_count,
    output logic               busy,
    output logic               err_ovf,
    output logic               err_proto
);

    typedef enum logic {S_IDLE = 1'b0, S_ACC = 1'b1} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   w_acc_nxt;
    logic [4:0]         r_cnt;
    logic [4:0]         w_cnt_nxt;
    logic [ACC_W-1:0]   r_out_result;
    logic [4:0]         r_out_count;
    logic               r_out_valid;
    logic               r_err_ovf;
    logic               r_err_proto;

    logic [ACC_W-1:0]   w_ext;
    logic [ACC_W-1:0]   w_term;
    logic [ACC_W-1:0]   w_sum;
    logic [4:0]         w_cnt_inc;
    logic               w_deliver;
    logic [ACC_W-1:0]   w_res;
    logic [4:0]         w_res_cnt;
    logic               w_proto;
    logic               w_load;
    logic               w_ovf;

    // Shifts of ACC_W or more yield zero, giving modulo-2^ACC_W arithmetic.
    assign w_ext     = ACC_W'(in_prod);
    assign w_term    = w_ext << in_shift;
    assign w_sum     = r_acc + w_term;
    assign w_cnt_inc = (r_cnt == 5'd31) ? 5'd31 : r_cnt + 5'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_deliver   = 1'b0;
        w_res       = '0;
        w_res_cnt   = '0;
        w_proto     = 1'b0;
        if (in_valid) begin
            if (in_first && in_last) begin
                w_acc_nxt   = w_term;
                w_cnt_nxt   = 5'd1;
                w_deliver   = 1'b1;
                w_res       = w_term;
                w_res_cnt   = 5'd1;
                w_state_nxt = S_IDLE;
            end else if (in_first) begin
                w_acc_nxt   = w_term;
                w_cnt_nxt   = 5'd1;
                w_proto     = (r_state == S_ACC);
                w_state_nxt = S_ACC;
            end else if (r_state == S_ACC) begin
                w_acc_nxt = w_sum;
                w_cnt_nxt = w_cnt_inc;
                if (in_last) begin
                    w_deliver   = 1'b1;
                    w_res       = w_sum;
                    w_res_cnt   = w_cnt_inc;
                    w_state_nxt = S_IDLE;
                end
            end else begin
                w_proto = 1'b1;
            end
        end
    end

    // The holding register can take a new result when empty or being drained this cycle.
    assign w_load = w_deliver && (!r_out_valid || out_ready);
    assign w_ovf  = w_deliver && r_out_valid && !out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_out_result <= '0;
            r_out_count  <= '0;
            r_out_valid  <= 1'b0;
            r_err_ovf    <= 1'b0;
            r_err_proto  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_load) begin
                r_out_result <= w_res;
                r_out_count  <= w_res_cnt;
                r_out_valid  <= 1'b1;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_ovf)   r_err_ovf   <= 1'b1;
            if (w_proto) r_err_proto <= 1'b1;
        end
    end

    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;
    assign out_count  = r_out_count;
    assign busy       = (r_state == S_ACC);
    assign err_ovf    = r_err_ovf;
    assign err_proto  = r_err_proto;

endmodule

// File: tb/tb_product_accumulator.sv
// tb/tb_product_accumulator.sv - directed-vector bench for product_accumulator
module tb_product_accumulator;

    localparam int PROD_W  = 77;
    localparam int ACC_W   = 265;
    localparam int SHIFT_W = 9;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_first;
    logic               in_last;
    logic [SHIFT_W-1:0] in_shift;
    logic [PROD_W-1:0]  in_prod;
    logic               out_valid;
    logic               out_ready;
    logic [ACC_W-1:0]   out_result;
    logic [4:0]         out_count;
    logic               busy;
    logic               err_ovf;
    logic               err_proto;

    int n_vec;
    int n_err;

    product_accumulator #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W),
        .SHIFT_W(SHIFT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_first  (in_first),
        .in_last   (in_last),
        .in_shift  (in_shift),
        .in_prod   (in_prod),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .out_count (out_count),
        .busy      (busy),
        .err_ovf   (err_ovf),
        .err_proto (err_proto)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [ACC_W-1:0] got, input logic [ACC_W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of input, then sample 1 ns after the rising edge.
    task automatic put(input logic v, input logic f, input logic l,
                       input logic [SHIFT_W-1:0] sh, input logic [PROD_W-1:0] p);
        in_valid = v;
        in_first = f;
        in_last  = l;
        in_shift = sh;
        in_prod  = p;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        put(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    logic [ACC_W-1:0] one;
    logic [ACC_W-1:0] exp_v;
    logic [PROD_W-1:0] p76;

    initial begin
        n_vec     = 0;
        n_err     = 0;
        one       = 1;
        p76       = 1;
        p76       = p76 << 76;
        rst       = 1'b1;
        out_ready = 1'b1;
        idle();
        idle();
        chk("rst_out_valid", ACC_W'(out_valid), 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_count", ACC_W'(out_count), 0);
        chk("rst_busy", ACC_W'(busy), 0);
        chk("rst_err_ovf", ACC_W'(err_ovf), 0);
        chk("rst_err_proto", ACC_W'(err_proto), 0);

        // Single product straight after reset release
        rst = 1'b0;
        put(1'b1, 1'b1, 1'b1, 9'd17, 77'h1_0000_0000);
        chk("single_valid", ACC_W'(out_valid), 1);
        chk("single_result", out_result, one << 49);
        chk("single_count", ACC_W'(out_count), 1);
        idle();
        chk("single_consumed", ACC_W'(out_valid), 0);

        // Schoolbook 2x2
        put(1'b1, 1'b1, 1'b0, 9'd0,  77'd5);
        put(1'b1, 1'b0, 1'b0, 9'd43, 77'd7);
        put(1'b1, 1'b0, 1'b0, 9'd34, 77'd3);
        chk("sb_busy", ACC_W'(busy), 1);
        chk("sb_no_early_valid", ACC_W'(out_valid), 0);
        put(1'b1, 1'b0, 1'b1, 9'd77, 77'd2);
        exp_v = 265'd5 + (265'd3 << 34) + (265'd7 << 43) + (one << 78);
        chk("sb_result", out_result, exp_v);
        chk("sb_count", ACC_W'(out_count), 4);
        chk("sb_idle", ACC_W'(busy), 0);
        idle();

        // Backpressure overflow
        out_ready = 1'b0;
        put(1'b1, 1'b1, 1'b1, 9'd0, 77'd11);
        put(1'b1, 1'b1, 1'b1, 9'd0, 77'd22);
        chk("ovf_held", out_result, 265'd11);
        chk("ovf_valid", ACC_W'(out_valid), 1);
        chk("ovf_flag", ACC_W'(err_ovf), 1);
        idle();
        chk("ovf_still_held", out_result, 265'd11);
        out_ready = 1'b1;
        idle();
        chk("ovf_drained", ACC_W'(out_valid), 0);

        // Wrap at the accumulator width
        put(1'b1, 1'b1, 1'b1, 9'd200, p76);
        chk("wrap_zero", out_result, 0);
        chk("wrap_zero_valid", ACC_W'(out_valid), 1);
        put(1'b1, 1'b1, 1'b1, 9'd188, p76);
        chk("wrap_top_bit", out_result, one << 264);
        idle();

        // Framing: non-first product while idle
        put(1'b1, 1'b0, 1'b0, 9'd0, 77'd9);
        chk("proto_flag", ACC_W'(err_proto), 1);
        chk("proto_dropped", ACC_W'(out_valid), 0);
        chk("proto_not_busy", ACC_W'(busy), 0);

        // Reset mid-accumulation
        put(1'b1, 1'b1, 1'b0, 9'd0, 77'd1);
        put(1'b1, 1'b0, 1'b0, 9'd0, 77'd1);
        rst = 1'b1;
        put(1'b1, 1'b0, 1'b0, 9'd0, 77'd1);
        chk("midrst_valid", ACC_W'(out_valid), 0);
        chk("midrst_busy", ACC_W'(busy), 0);
        chk("midrst_proto", ACC_W'(err_proto), 0);
        chk("midrst_ovf", ACC_W'(err_ovf), 0);
        rst = 1'b0;
        put(1'b1, 1'b1, 1'b1, 9'd4, 77'd9);
        chk("postrst_result", out_result, 265'd144);
        chk("postrst_count", ACC_W'(out_count), 1);
        idle();

        // Back-to-back results with no bubble
        put(1'b1, 1'b1, 1'b0, 9'd0, 77'd1);
        put(1'b1, 1'b0, 1'b1, 9'd1, 77'd1);
        chk("b2b_a_valid", ACC_W'(out_valid), 1);
        chk("b2b_a_result", out_result, 265'd3);
        chk("b2b_a_count", ACC_W'(out_count), 2);
        put(1'b1, 1'b1, 1'b1, 9'd2, 77'd5);
        chk("b2b_b_valid", ACC_W'(out_valid), 1);
        chk("b2b_b_result", out_result, 265'd20);
        chk("b2b_b_count", ACC_W'(out_count), 1);
        idle();

        // Count saturation: 33 products of 1
        for (int i = 0; i < 33; i++)
            put(1'b1, i == 0, i == 32, 9'd0, 77'd1);
        chk("sat_result", out_result, 265'd33);
        chk("sat_count", ACC_W'(out_count), 31);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 SHALL have parameter PROD_W, default 77: width of one incoming partial product, matching the 34x43 Karatsuba tile output.
REQ-002 SHALL have parameter ACC_W, default 265: accumulator and result width.
REQ-003 SHALL have parameter SHIFT_W, default 9: width of the shift field.
REQ-004 clk  input  1  single clock; all logic on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  in_prod is valid this cycle; no backpressure, so the block accepts every valid.
REQ-007 in_first  input  1  first partial product of a result.
REQ-008 in_last  input  1  last partial product of a result.
REQ-009 in_shift  input  SHIFT_W  left-shift in bits applied to in_prod.
REQ-010 in_prod  input  PROD_W  unsigned partial product.
REQ-011 out_valid  output  1  out_result holds a completed result.
REQ-012 out_ready  input  1  consumer takes the result when asserted together with out_valid.
REQ-013 out_result  output  ACC_W  completed sum.
REQ-014 out_count  output  5  number of products summed into out_result, saturating at 31.
REQ-015 busy  output  1  state is ACC.
REQ-016 err_ovf  output  1  sticky flag: a result was dropped because the output register was full.
REQ-017 err_proto  output  1  sticky flag: a framing violation occurred.

Function
REQ-018 SHALL form the term (in_prod zero-extended to ACC_W) << in_shift; bits above ACC_W-1 are discarded, so the sum is modulo 2^ACC_W.
REQ-019 SHALL implement an FSM with two states:
- IDLE: no accumulation open.
- ACC: accumulation open.
REQ-020 In IDLE, on in_valid & in_first & !in_last: acc = term, cnt = 1, go to ACC.
REQ-021 In any state, on in_valid & in_first & in_last: the result is term and cnt = 1; the result is delivered per REQ-025; the next state is IDLE.
REQ-022 In ACC, on in_valid & !in_first: acc += term, cnt = sat(cnt+1).
- If in_last is also set, deliver acc+term with the updated cnt, then go to IDLE.
REQ-023 In ACC, on in_valid & in_first & !in_last: the open sum is abandoned, acc = term, cnt = 1, state stays ACC, err_proto is set.
REQ-024 In IDLE, on in_valid & !in_first: the product is dropped, err_proto is set, state is unchanged.
REQ-025 Result delivery happens in the cycle in_last is accepted:
- The output register loads if it is empty, or if out_valid & out_ready in that same cycle.
- Otherwise the new result is dropped, err_ovf is set, and the held result is unchanged.
REQ-026 out_valid SHALL rise the cycle after the in_last product is sampled (latency 1).
- out_valid stays high, with out_result/out_count stable, until out_valid & out_ready.
REQ-027 Simultaneous consume and load SHALL keep out_valid high with the new data and no bubble.
REQ-028 in_valid low SHALL leave acc, cnt and state unchanged; in_first/in_last/in_shift are ignored.
REQ-029 Sustained throughput SHALL be one product per cycle, including back-to-back results (last followed immediately by first).

Reset
REQ-030 rst SHALL force the following at the next edge, with rst taking priority over all inputs:
- state = IDLE;
- out_valid = 0, busy = 0, err_ovf = 0, err_proto = 0;
- out_result = 0, out_count = 0, acc = 0, cnt = 0.
REQ-031 rst asserted mid-accumulation or with a pending output SHALL discard both, with no result emitted.
REQ-032 The first cycle after rst deasserts SHALL accept a valid in_first product.

Verification
REQ-033 Single product: in_prod=0x1_0000_0000, first=last=1, shift=17 -> next cycle out_valid=1, out_result=2^49, out_count=1.
REQ-034 Schoolbook 2x2: products P00=5 (shift 0), P01=7 (shift 43), P10=3 (shift 34), P11=2 (shift 77) over 4 consecutive cycles, first on P00, last on P11 -> out_result=5+3*2^34+7*2^43+2^78, out_count=4.
REQ-035 Backpressure overflow: complete result R1 with out_ready=0, then complete result R2 -> out_result stays R1 and err_ovf=1; raise out_ready -> R1 consumed, out_valid=0.
REQ-036 Wrap: in_prod=2^76, shift=200, single product -> out_result=0 (bit 276 discarded); shift=188 -> out_result=2^264.
REQ-037 Framing and reset:
- !first product in IDLE -> dropped, err_proto=1.
- rst asserted after 2 of 4 products -> no out_valid; a following 1-product result is correct.
REQ-038 Back-to-back: last of result A and first of result B in adjacent cycles, out_ready=1 throughout -> both results correct, out_valid high in 2 consecutive windows with no bubble.
